// File: rtl/float_to_fixed_seq.sv
// Sequential float16 -> signed fixed 8.8 converter with a start/done handshake.
// Mantissa alignment uses a serial 1-bit-per-cycle shifter, so latency tracks the exponent.
module float_to_fixed_seq #(
  parameter logic [15:0] NAN_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] flt_in,
  output logic [15:0] fix_out,
  output logic        done,
  output logic        busy,
  output logic        ovf
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_SHIFT,
    S_FINISH,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        s_q;
  logic [4:0]  e_q;
  logic [9:0]  m_q;
  logic [15:0] mag;
  logic        shift_left;
  logic [3:0]  count;
  logic        special;
  logic [15:0] special_val;

  logic        dec_nan;
  logic        dec_sat;
  logic        dec_left;
  logic [3:0]  dec_n;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // SHIFT is always entered once and stays until the down-counter hits zero.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_DECODE;
      S_DECODE: state_next = S_SHIFT;
      S_SHIFT:  if (count == 4'd0) state_next = S_FINISH;
      S_FINISH: state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  assign done = (state == S_DONE);
  assign busy = (state != S_IDLE);

  // Value is {1,m} * 2^(e-17) in 8.8 units; e=22 only fits for exactly -128.
  always_comb begin
    dec_nan  = (e_q == 5'd31) && (m_q != 10'd0);
    dec_sat  = !dec_nan && ((e_q > 5'd22) ||
               ((e_q == 5'd22) && (!s_q || (m_q != 10'd0))));
    dec_left = (e_q >= 5'd17);
    dec_n    = 4'd0;
    if ((e_q == 5'd0) || dec_nan || dec_sat) dec_n = 4'd0;
    else if (dec_left)                       dec_n = 4'(e_q - 5'd17);
    else if (e_q <= 5'd6)                    dec_n = 4'd11;
    else                                     dec_n = 4'(5'd17 - e_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q         <= 1'b0;
      e_q         <= 5'd0;
      m_q         <= 10'd0;
      mag         <= 16'd0;
      shift_left  <= 1'b0;
      count       <= 4'd0;
      special     <= 1'b0;
      special_val <= 16'd0;
      fix_out     <= 16'd0;
      ovf         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            s_q <= flt_in[15];
            e_q <= flt_in[14:10];
            m_q <= flt_in[9:0];
          end
        end
        S_DECODE: begin
          mag         <= (e_q == 5'd0) ? 16'd0 : {5'b0, 1'b1, m_q};
          shift_left  <= dec_left;
          count       <= dec_n;
          special     <= dec_nan | dec_sat;
          special_val <= dec_nan ? NAN_VAL : (s_q ? 16'h8000 : 16'h7FFF);
        end
        S_SHIFT: begin
          if (count != 4'd0) begin
            mag   <= shift_left ? (mag << 1) : (mag >> 1);
            count <= count - 4'd1;
          end
        end
        S_FINISH: begin
          if (special) begin
            fix_out <= special_val;
            ovf     <= 1'b1;
          end else begin
            fix_out <= s_q ? (~mag + 16'd1) : mag;
            ovf     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/float_to_fixed_seq.md
Name: float_to_fixed_seq

Overview:
- Sequential converter from IEEE half-precision float (1 sign, 5-bit exponent with bias 15, 10-bit mantissa) to signed two's-complement fixed 8.8.
- Inverse companion of the fixed(8.8)-to-float16 program datapath.
- Used as a hardware reference model and co-processor, with the same start/done handshake as top_level.
- Mantissa is aligned by a serial 1-bit-per-cycle shifter, so latency depends on the exponent.

Parameters:
- NAN_VAL, 16'h0000: fix_out value returned for a NaN input.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- flt_in  input  16  float16 operand; captured on the start cycle
- fix_out  output  16  fixed 8.8 result; held until the next accepted start
- done  output  1  one-cycle pulse when fix_out is valid
- busy  output  1  high in every state except IDLE
- ovf  output  1  saturation or NaN indicator; valid with done, held with fix_out

Behaviour:
- Reset (synchronous, active-high): state=IDLE; fix_out=0, done=0, busy=0, ovf=0. Reset mid-operation aborts the operation, produces no done, and clears all outputs.
- States: IDLE -> DECODE -> SHIFT (N cycles, N may be 0) -> FINISH -> DONE -> IDLE.
- IDLE: if start=1, latch s=flt_in[15], e=flt_in[14:10], m=flt_in[9:0] and go to DECODE. start is ignored in every other state.
- DECODE:
  - mag (16-bit) = {5'b0, 1, m}.
  - Shift amount k = e - 17.
  - e=0 (zero or subnormal): mag=0, N=0.
  - e=31, m!=0 (NaN): result NAN_VAL, ovf=1, N=0.
  - e=31, m=0 (infinity): saturate.
  - e>22, or e=22 with (s=0 or m!=0): saturate, N=0. Saturate means result 0x7FFF if s=0, 0x8000 if s=1, ovf=1.
  - 17<=e<=22: left shift, N=e-17 (0..5).
  - 1<=e<=16: right shift, N=min(17-e, 11).
- SHIFT: one 1-bit logical shift of mag per cycle in the decoded direction. Down-counter; leave SHIFT when the count reaches 0.
- Right shifts truncate the magnitude toward zero. There is no rounding, matching the truncating forward conversion.
- FINISH: if not special, fix_out = s ? (~mag+1) : mag, using 16-bit wrap. A -0 input yields 0x0000. fix_out and ovf update here.
- DONE: done=1 for exactly one cycle, then IDLE. start is accepted again in the cycle after DONE.
- Latency: start sampled at edge T gives done high during the cycle after edge T+3+N (done visible 3+N cycles after the start edge). Minimum 3 cycles (N=0); maximum 14 cycles (N=11).
- fix_out and ovf are stable from FINISH until the FINISH of the next operation.
- busy goes high in the cycle after start is accepted and drops when the state returns to IDLE.
- Every fixed-point value that converts exactly through the forward path round-trips bit-exact.

Test Plan:
- Reset with outputs at 0, then flt_in=0x3C00 (1.0) with a start pulse -> N=2; fix_out=0x0100, ovf=0, done 5 cycles after the start edge, single-cycle pulse.
- flt_in=0x2000 (2^-7) -> N=9; fix_out=0x0002. flt_in=0xBA00 (-0.75) -> N=3; fix_out=0xFF40, ovf=0.
- flt_in=0xD800 (-128) -> N=5 left shifts; fix_out=0x8000, ovf=0, done at start+8. flt_in=0x5800 (+128) -> fix_out=0x7FFF, ovf=1, done at start+3.
- flt_in=0x7C00 -> 0x7FFF, ovf=1; 0xFC00 -> 0x8000, ovf=1; 0x7E00 -> NAN_VAL (0x0000), ovf=1; 0x8000 (-0) -> 0x0000, ovf=0; 0x0001 (subnormal) -> 0x0000.
- Pulse start again while busy -> ignored, result unchanged. Assert reset during SHIFT -> no done, outputs return to 0, and the next start converts correctly.
- Random fixed 8.8 inputs run through the bench's fixed-to-float math model, then through this DUT -> output equals the original truncated to the float's precision; report a score over more than 100 trials.
